// File: rtl/mc_controller_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle controller.
//   state_t      - controller FSM states
//   OP_*         - Instr[27:26] instruction classes
//   COND_*       - Instr[31:28] condition codes
//   ALU_*        - ALUControl encodings
//   RES_*/SRCB_* - ResultSrc / ALUSrcB mux encodings
//   alu_decode   - Funct[4:1] -> {valid, ALUControl}
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
        MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    // Unsupported commands execute as ADD but are flagged invalid so the
    // register writeback can be suppressed.
    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {1'b1, ALU_ADD};
            4'b0010: return {1'b1, ALU_SUB};
            4'b0000: return {1'b1, ALU_AND};
            4'b1100: return {1'b1, ALU_ORR};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> multicycle datapath signal bundle.
//   master (controller): drives all selects/enables, reads Instr/ALUFlags/MemReady
//   slave  (datapath)  : the reverse direction
interface mc_controller_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         MemReady;
    logic         PCWrite;
    logic         MemWrite;
    logic         RegWrite;
    logic         IRWrite;
    logic         AdrSrc;
    logic [1:0]   ResultSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ALUControl;
    logic [1:0]   ImmSrc;
    logic [1:0]   RegSrc;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc
    );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// cond_unit: NZCV flag register, flag write logic and condition evaluation.
//   clk, rst_n  - clock, async active-low reset (clears flags)
//   cond        - Instr[31:28]
//   alu_flags   - NZCV from the ALU this cycle
//   flag_we     - S-bit flag update requested this cycle
//   cv_we       - C and V may be updated (ADD/SUB)
//   cond_ex     - instruction condition satisfied
// With MC_CTRL_COND_EN undefined the unit is a pass-through (cond_ex = 1)
// and holds no flag state.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_we,
    input  logic       cv_we,
    output logic       cond_ex
);

`ifdef MC_CTRL_COND_EN
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_we && cond_ex) begin
            flags_d[3:2] = alu_flags[3:2];
            if (cv_we) begin
                flags_d[1:0] = alu_flags[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, cond, alu_flags, flag_we, cv_we};
    assign cond_ex       = 1'b1;
`endif

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM-subset processor.
// Sequences fetch/decode/execute/writeback over a shared ALU, register file
// and unified memory, stalling on MemReady.
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - mc_controller_if.master: Instr, ALUFlags, MemReady in;
//           PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
//           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc out
// Build option: define MC_CTRL_COND_EN for conditional execution and NZCV
// flags; otherwise every instruction executes unconditionally.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mc_controller_if.master  bus
);

    state_t     state_q;
    state_t     state_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] unused_rn;
    logic       alu_valid;
    logic [1:0] alu_ctrl;
    logic       cond_ex;
    logic       flag_we;
    logic       cv_we;

    logic       pc_write_c;
    logic       mem_write_c;
    logic       reg_write_c;
    logic       ir_write_c;
    logic       adr_src_c;
    logic [1:0] result_src_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_control_c;

    assign cond      = bus.Instr[31:28];
    assign op        = bus.Instr[27:26];
    assign funct     = bus.Instr[25:20];
    assign unused_rn = bus.Instr[19:16];
    assign rd        = bus.Instr[15:12];

    assign {alu_valid, alu_ctrl} = alu_decode(funct[4:1]);

    assign flag_we = reset && (state_q == EXECR || state_q == EXECI) && funct[0];
    assign cv_we   = (alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB);

    cond_unit u_cond_unit (
        .clk       (clk),
        .rst_n     (reset),
        .cond      (cond),
        .alu_flags (bus.ALUFlags),
        .flag_we   (flag_we),
        .cv_we     (cv_we),
        .cond_ex   (cond_ex)
    );

    always_comb begin
        state_d       = state_q;
        pc_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        reg_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        adr_src_c     = 1'b0;
        result_src_c  = '0;
        alu_src_a_c   = 1'b0;
        alu_src_b_c   = '0;
        alu_control_c = ALU_ADD;

        case (state_q)
            FETCH: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = bus.MemReady;
                pc_write_c   = bus.MemReady;
                if (bus.MemReady) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                case (op)
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    OP_DP:   state_d = funct[5] ? EXECI : EXECR;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b_c = SRCB_EXTIMM;
                state_d     = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src_c = 1'b1;
                if (bus.MemReady) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = cond_ex;
                state_d      = FETCH;
            end
            MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = cond_ex;
                if (bus.MemReady) begin
                    state_d = FETCH;
                end
            end
            EXECR: begin
                alu_src_b_c   = SRCB_RD2;
                alu_control_c = alu_ctrl;
                state_d       = ALUWB;
            end
            EXECI: begin
                alu_src_b_c   = SRCB_EXTIMM;
                alu_control_c = alu_ctrl;
                state_d       = ALUWB;
            end
            ALUWB: begin
                // Instr is still held here, so the command and Rd are
                // re-decoded rather than carried over from EXEC.
                result_src_c = RES_ALUOUT;
                if (alu_valid) begin
                    if (rd == 4'd15) begin
                        pc_write_c = cond_ex;
                    end else begin
                        reg_write_c = cond_ex;
                    end
                end
                state_d = FETCH;
            end
            BRANCH: begin
                alu_src_b_c  = SRCB_EXTIMM;
                result_src_c = RES_ALURESULT;
                pc_write_c   = cond_ex;
                state_d      = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset forces every output low combinationally so no write can slip
    // through while reset is asserted mid-instruction.
    assign bus.PCWrite    = reset & pc_write_c;
    assign bus.MemWrite   = reset & mem_write_c;
    assign bus.RegWrite   = reset & reg_write_c;
    assign bus.IRWrite    = reset & ir_write_c;
    assign bus.AdrSrc     = reset & adr_src_c;
    assign bus.ResultSrc  = reset ? result_src_c  : '0;
    assign bus.ALUSrcA    = reset & alu_src_a_c;
    assign bus.ALUSrcB    = reset ? alu_src_b_c   : '0;
    assign bus.ALUControl = reset ? alu_control_c : '0;
    assign bus.ImmSrc     = reset ? op            : '0;
    assign bus.RegSrc     = reset ? {op == OP_MEM, op == OP_BR} : '0;

endmodule
